chunk_slave: RTL and testbench

CHUNK_SLAVE -- requirements
Module: chunk_slave

---
 rtl/chunk_if.sv | 56 +++++
 rtl/chunk_slave.sv | 128 ++++++++++++
 tb/tb_chunk_slave.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chunk_if.sv
// Bundle of the chunk-assignment, sample-read and completion channels between
// a chunk master (which also fronts the sample memory) and one chunk slave.
//
// Valid/ready semantics for every channel here: a transfer happens on a rising
// clk edge where both valid and ready are 1. A sender holds valid and its payload
// stable until that edge. Ready may be asserted before valid and may be
// withdrawn freely. The read-response channel has no ready: a response is
// consumed on every edge where rd_rsp_valid is 1, and responses come back in
// request order.
interface chunk_if #(
  parameter int VCHANNELBITS = 3,
  parameter int SLAVEBITS    = 2
);
  logic                    asgn_valid;
  logic                    asgn_ready;
  logic [9:0]              asgn_chunk;
  logic [31:0]             asgn_start;
  logic [31:0]             asgn_end;
  logic [VCHANNELBITS-1:0] asgn_vc;

  logic                    rd_req_valid;
  logic                    rd_req_ready;
  logic [31:0]             rd_req_addr;
  logic                    rd_rsp_valid;
  logic [31:0]             rd_rsp_data;

  logic                    done_valid;
  logic                    done_ready;
  logic [9:0]              done_chunk;
  logic [VCHANNELBITS-1:0] done_vc;
  logic [SLAVEBITS-1:0]    done_slave;
  logic [31:0]             done_count;
  logic [47:0]             done_sum;

  logic                    proto_err;

  modport slave (
    input  asgn_valid, asgn_chunk, asgn_start, asgn_end, asgn_vc,
    output asgn_ready,
    output rd_req_valid, rd_req_addr,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data,
    output done_valid, done_chunk, done_vc, done_slave, done_count, done_sum,
    input  done_ready,
    output proto_err
  );

  modport master (
    output asgn_valid, asgn_chunk, asgn_start, asgn_end, asgn_vc,
    input  asgn_ready,
    input  rd_req_valid, rd_req_addr,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data,
    input  done_valid, done_chunk, done_vc, done_slave, done_count, done_sum,
    output done_ready,
    input  proto_err
  );
endinterface

// File: rtl/chunk_slave.sv
// Chunk slave: accepts a [start, end) index range, streams one read request
// per index with at most MAX_OUT responses outstanding, sums the returned
// samples (48-bit wrap) and reports chunk/vc/count/sum back to the master.
// Every output is a function of registers only; dbg_state exposes the FSM
// (0 IDLE, 1 ISSUE, 2 DRAIN, 3 REPORT).
module chunk_slave #(
  parameter int VCHANNELBITS = 3,
  parameter int SLAVEBITS    = 2,
  parameter int SLAVE_ID     = 0,
  parameter int MAX_OUT      = 4
) (
  input  logic       clk,
  input  logic       rst,
  chunk_if.slave     bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_t;

  // MAX_OUT is limited to 1..15, so a 4-bit counter always suffices.
  localparam logic [3:0] MAX_OUT_L = 4'(MAX_OUT);

  state_t                  state;
  logic                    accepting;
  logic [3:0]              outstanding;
  logic [31:0]             next_idx;
  logic [31:0]             end_idx;
  logic [9:0]              cur_chunk;
  logic [VCHANNELBITS-1:0] cur_vc;
  logic [47:0]             sum;
  logic [31:0]             count;
  logic                    err_flag;

  logic req_fire;
  logic rsp_ok;

  // A response only counts when something is actually in flight.
  assign req_fire = bus.rd_req_valid && bus.rd_req_ready;
  assign rsp_ok   = bus.rd_rsp_valid && (outstanding != 4'd0);

  assign bus.asgn_ready   = accepting;
  assign bus.rd_req_valid = (state == ISSUE) && (outstanding < MAX_OUT_L);
  assign bus.rd_req_addr  = next_idx;
  assign bus.done_valid   = (state == REPORT);
  assign bus.done_chunk   = cur_chunk;
  assign bus.done_vc      = cur_vc;
  assign bus.done_slave   = SLAVEBITS'(SLAVE_ID);
  assign bus.done_count   = count;
  assign bus.done_sum     = sum;
  assign bus.proto_err    = err_flag;
  assign dbg_state        = state;

  // FSM, in-flight accounting and accumulation in one registered process.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      accepting   <= 1'b0;
      outstanding <= 4'd0;
      next_idx    <= 32'd0;
      end_idx     <= 32'd0;
      cur_chunk   <= 10'd0;
      cur_vc      <= '0;
      sum         <= 48'd0;
      count       <= 32'd0;
      err_flag    <= 1'b0;
    end else begin
      if (req_fire && !rsp_ok) begin
        outstanding <= outstanding + 4'd1;
      end else if (!req_fire && rsp_ok) begin
        outstanding <= outstanding - 4'd1;
      end

      if (rsp_ok) begin
        sum   <= sum + {16'd0, bus.rd_rsp_data};
        count <= count + 32'd1;
      end

      // Sticky: a response with nothing in flight, including stale ones
      // from before a reset.
      if (bus.rd_rsp_valid && (outstanding == 4'd0)) begin
        err_flag <= 1'b1;
      end

      case (state)
        IDLE: begin
          accepting <= 1'b1;
          if (bus.asgn_valid && accepting) begin
            accepting <= 1'b0;
            cur_chunk <= bus.asgn_chunk;
            cur_vc    <= bus.asgn_vc;
            next_idx  <= bus.asgn_start;
            end_idx   <= bus.asgn_end;
            sum       <= 48'd0;
            count     <= 32'd0;
            // Empty or inverted ranges report straight away.
            state     <= (bus.asgn_start < bus.asgn_end) ? ISSUE : REPORT;
          end
        end
        ISSUE: begin
          if (req_fire) begin
            next_idx <= next_idx + 32'd1;
            if (next_idx + 32'd1 == end_idx) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (outstanding == 4'd0) begin
            state <= REPORT;
          end
        end
        REPORT: begin
          if (bus.done_ready) begin
            state     <= IDLE;
            accepting <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_slave.sv
// Bench for chunk_slave: directed scenarios plus randomized chunks, with a
// transaction-level reference model checked against the DUT on every cycle.
module tb_chunk_slave;
  localparam int VCB  = 3;
  localparam int SB   = 2;
  localparam int SID  = 2;
  localparam int MAXO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  chunk_if #(.VCHANNELBITS(VCB), .SLAVEBITS(SB)) bus ();

  chunk_slave #(
    .VCHANNELBITS(VCB),
    .SLAVEBITS(SB),
    .SLAVE_ID(SID),
    .MAX_OUT(MAXO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- sample memory ----------------
  int          mem_mode  = 0;   // 0: data = index, 1: hashed, 2: all ones
  bit          rsp_hold  = 1'b0;
  int          rsp_pct   = 100;
  bit          rand_ready = 1'b0;
  logic [31:0] mem_q[$];        // indices requested, awaiting response

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    case (mem_mode)
      0:       return a;
      1:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // ---------------- reference model ----------------
  bit               m_active   = 1'b0;  // chunk accepted, not yet reported back
  bit               m_report   = 1'b0;  // completion being offered
  bit               m_prev_rst = 1'b1;  // rst was high at the last edge
  bit               m_perr     = 1'b0;
  int               m_out      = 0;
  logic [31:0]      exp_q[$];           // indices still to be requested, in order
  logic [9:0]       m_chunk;
  logic [VCB-1:0]   m_vc;
  logic [31:0]      m_count;
  logic [47:0]      m_sum;

  task automatic model_accept();
    longint unsigned s;
    s = 0;
    m_chunk = bus.asgn_chunk;
    m_vc    = bus.asgn_vc;
    exp_q.delete();
    if (bus.asgn_start < bus.asgn_end) begin
      for (longint unsigned a = bus.asgn_start; a < bus.asgn_end; a++) begin
        exp_q.push_back(32'(a));
        s += mem_data(32'(a));
      end
      m_count  = bus.asgn_end - bus.asgn_start;
      m_report = 1'b0;
    end else begin
      m_count  = 32'd0;
      m_report = 1'b1;
    end
    m_sum    = s[47:0];
    m_active = 1'b1;
  endtask

  // Memory responder, per-cycle compare, then advance the model across the
  // coming rising edge using the inputs that edge will sample.
  always @(negedge clk) begin
    bit exp_req;
    bit was_idle;

    if (!rsp_hold && mem_q.size() > 0 && $urandom_range(0, 99) < rsp_pct) begin
      bus.rd_rsp_valid = 1'b1;
      bus.rd_rsp_data  = mem_data(mem_q.pop_front());
    end else begin
      bus.rd_rsp_valid = 1'b0;
      bus.rd_rsp_data  = $urandom;
    end

    exp_req = m_active && !m_report && (exp_q.size() > 0) && (m_out < MAXO);
    check("asgn_ready", 64'(bus.asgn_ready), 64'(!m_active && !m_prev_rst));
    check("rd_req_valid", 64'(bus.rd_req_valid), 64'(exp_req));
    if (exp_req) check("rd_req_addr", 64'(bus.rd_req_addr), 64'(exp_q[0]));
    check("done_valid", 64'(bus.done_valid), 64'(m_report));
    if (m_report) begin
      check("done_chunk", 64'(bus.done_chunk), 64'(m_chunk));
      check("done_vc", 64'(bus.done_vc), 64'(m_vc));
      check("done_count", 64'(bus.done_count), 64'(m_count));
      check("done_sum", 64'(bus.done_sum), 64'(m_sum));
    end
    check("done_slave", 64'(bus.done_slave), 64'(SID));
    check("proto_err", 64'(bus.proto_err), 64'(m_perr));
    if (m_prev_rst) begin
      check("rst_addr", 64'(bus.rd_req_addr), 64'd0);
      check("rst_payload", 64'({bus.done_chunk, bus.done_count}), 64'd0);
      check("rst_sum", 64'(bus.done_sum), 64'd0);
    end

    if (!rst && bus.rd_req_valid && bus.rd_req_ready) mem_q.push_back(bus.rd_req_addr);

    if (rst) begin
      m_active   = 1'b0;
      m_report   = 1'b0;
      m_out      = 0;
      m_perr     = 1'b0;
      m_prev_rst = 1'b1;
      exp_q.delete();
    end else begin
      was_idle = !m_active && !m_prev_rst;
      if (m_report) begin
        if (bus.done_ready) begin
          m_active = 1'b0;
          m_report = 1'b0;
        end
      end else if (m_active && exp_q.size() == 0 && m_out == 0) begin
        m_report = 1'b1;
      end
      if (bus.rd_rsp_valid) begin
        if (m_out == 0) m_perr = 1'b1;
        else m_out--;
      end
      if (exp_req && bus.rd_req_ready) begin
        void'(exp_q.pop_front());
        m_out++;
      end
      if (was_idle && bus.asgn_valid) model_accept();
      m_prev_rst = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) bus.rd_req_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic assign_chunk(input logic [9:0] ch, input logic [VCB-1:0] vc,
                              input logic [31:0] s, input logic [31:0] e);
    int n;
    n = 0;
    bus.asgn_valid = 1'b1;
    bus.asgn_chunk = ch;
    bus.asgn_vc    = vc;
    bus.asgn_start = s;
    bus.asgn_end   = e;
    while (!bus.asgn_ready && n < 50) begin
      step();
      n++;
    end
    check("asgn_accept_timeout", 64'(n < 50), 64'd1);
    step();
    bus.asgn_valid = 1'b0;
    bus.asgn_chunk = 10'($urandom);
    bus.asgn_start = $urandom;
    bus.asgn_end   = $urandom;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (!bus.done_valid && n < bound) begin
      step();
      n++;
    end
    check("done_timeout", 64'(bus.done_valid), 64'd1);
  endtask

  task automatic check_payload(input logic [9:0] ch, input logic [VCB-1:0] vc,
                               input logic [31:0] cnt, input logic [47:0] sum);
    check("lit_chunk", 64'(bus.done_chunk), 64'(ch));
    check("lit_vc", 64'(bus.done_vc), 64'(vc));
    check("lit_count", 64'(bus.done_count), 64'(cnt));
    check("lit_sum", 64'(bus.done_sum), 64'(sum));
  endtask

  task automatic release_done();
    bus.done_ready = 1'b1;
    step();
    bus.done_ready = 1'b0;
    check("idle_after_done", 64'(bus.asgn_ready), 64'd1);
    check("state_after_done", 64'(dbg_state), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_500_000;
    failures++;
    $display("FAIL watchdog: time limit reached before the test sequence ended");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    int nreq;
    int n;
    logic [31:0] s;
    logic [31:0] e;

    bus.asgn_valid   = 1'b0;
    bus.asgn_chunk   = 10'd0;
    bus.asgn_start   = 32'd0;
    bus.asgn_end     = 32'd0;
    bus.asgn_vc      = '0;
    bus.rd_req_ready = 1'b1;
    bus.done_ready   = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_asgn_ready", 64'(bus.asgn_ready), 64'd0);
    check("rst_req_valid", 64'(bus.rd_req_valid), 64'd0);
    check("rst_done_valid", 64'(bus.done_valid), 64'd0);
    check("rst_proto_err", 64'(bus.proto_err), 64'd0);
    rst = 1'b0;
    step();
    check("ready_after_rst", 64'(bus.asgn_ready), 64'd1);

    // Chunk 5, vc 3, [10,14), data = index: back-to-back addresses, sum 46.
    mem_mode = 0;
    assign_chunk(10'd5, 3'd3, 32'd10, 32'd14);
    for (int i = 0; i < 4; i++) begin
      check("c1_req_valid", 64'(bus.rd_req_valid), 64'd1);
      check("c1_req_addr", 64'(bus.rd_req_addr), 64'(10 + i));
      step();
    end
    wait_done(20);
    check_payload(10'd5, 3'd3, 32'd4, 48'd46);
    release_done();

    // Responses withheld: only MAX_OUT requests go out, then a stall.
    rsp_hold = 1'b1;
    assign_chunk(10'd6, 3'd1, 32'd100, 32'd108);
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rd_req_valid) nreq++;
      step();
    end
    check("maxout_reqs", 64'(nreq), 64'(MAXO));
    check("maxout_stall", 64'(bus.rd_req_valid), 64'd0);
    rsp_hold = 1'b0;
    n = 0;
    while (!bus.rd_req_valid && n < 5) begin
      step();
      n++;
    end
    check("maxout_resume", 64'(bus.rd_req_valid), 64'd1);
    wait_done(40);
    // Hold off done_ready for 5 cycles; payload must sit still (100..107 -> 828).
    for (int i = 0; i < 5; i++) begin
      check("hold_done_valid", 64'(bus.done_valid), 64'd1);
      check("hold_asgn_ready", 64'(bus.asgn_ready), 64'd0);
      check_payload(10'd6, 3'd1, 32'd8, 48'd828);
      step();
    end
    release_done();

    // Empty and inverted ranges: done on the very next cycle, nothing issued.
    assign_chunk(10'd7, 3'd2, 32'd20, 32'd20);
    check("empty_done", 64'(bus.done_valid), 64'd1);
    check("empty_req", 64'(bus.rd_req_valid), 64'd0);
    check_payload(10'd7, 3'd2, 32'd0, 48'd0);
    release_done();
    assign_chunk(10'd8, 3'd6, 32'd30, 32'd7);
    check("inverted_done", 64'(bus.done_valid), 64'd1);
    check("inverted_req", 64'(bus.rd_req_valid), 64'd0);
    check_payload(10'd8, 3'd6, 32'd0, 48'd0);
    release_done();

    // Randomized chunks: random ready, response gaps and done delays.
    mem_mode   = 1;
    rand_ready = 1'b1;
    assign_chunk(10'd900, 3'd7, 32'hFFFF_FFF8, 32'hFFFF_FFFF);
    wait_done(400);
    release_done();
    for (int k = 0; k < 15; k++) begin
      s = $urandom;
      if (s > 32'hFFFF_FF00) s = s - 32'h100;
      if ($urandom_range(0, 5) == 0) e = s - 32'($urandom_range(0, 5));
      else e = s + 32'($urandom_range(1, 24));
      rsp_pct = $urandom_range(30, 100);
      assign_chunk(10'(k + 100), 3'($urandom_range(0, 7)), s, e);
      wait_done(400);
      repeat ($urandom_range(0, 3)) step();
      release_done();
    end

    // 65538 samples of 0xFFFFFFFF: 0xFFFFFFFF * 0x10002 = 0x1_0001_FFFE_FFFE,
    // which wraps to 0x0001_FFFE_FFFE in 48 bits.
    rand_ready       = 1'b0;
    bus.rd_req_ready = 1'b1;
    rsp_pct          = 100;
    mem_mode         = 2;
    assign_chunk(10'd9, 3'd5, 32'd0, 32'd65538);
    wait_done(70000);
    check_payload(10'd9, 3'd5, 32'd65538, 48'h0001_FFFE_FFFE);
    release_done();

    // Reset mid-ISSUE with two responses in flight; they arrive afterwards.
    mem_mode         = 0;
    rsp_hold         = 1'b1;
    bus.rd_req_ready = 1'b0;
    assign_chunk(10'd11, 3'd4, 32'd200, 32'd210);
    bus.rd_req_ready = 1'b1;
    step();
    step();
    bus.rd_req_ready = 1'b0;
    check("mid_state_issue", 64'(dbg_state), 64'd1);
    rst = 1'b1;
    step();
    check("mid_rst_ready", 64'(bus.asgn_ready), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'd0);
    rst      = 1'b0;
    rsp_hold = 1'b0;
    repeat (4) step();
    check("stray_state", 64'(dbg_state), 64'd0);
    check("stray_proto_err", 64'(bus.proto_err), 64'd1);
    check("stray_sum", 64'(bus.done_sum), 64'd0);
    check("stray_count", 64'(bus.done_count), 64'd0);
    check("stray_ready", 64'(bus.asgn_ready), 64'd1);

    // proto_err stays set through a normal chunk, clears only on reset.
    bus.rd_req_ready = 1'b1;
    assign_chunk(10'd12, 3'd0, 32'd5, 32'd8);
    wait_done(40);
    check_payload(10'd12, 3'd0, 32'd3, 48'd18);
    check("sticky_proto_err", 64'(bus.proto_err), 64'd1);
    release_done();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("proto_err_cleared", 64'(bus.proto_err), 64'd0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
